// File: rtl/subleq_read_port_if.sv
// Read-side bus bundle for subleq_read_port: CPU read request, synchronous RAM
// request/return, and the input device valid/ready byte stream.
interface subleq_read_port_if;
   logic       RE;
   logic [7:0] addrRead;
   logic [7:0] dataRead;
   logic       readValid;
   logic       BUSY;
   logic [7:0] ram_addr;
   logic       ram_re;
   logic [7:0] ram_data;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport slave (
      input  RE, addrRead, ram_data, in_data, in_valid,
      output dataRead, readValid, BUSY, ram_addr, ram_re, in_ready
   );

   modport master (
      output RE, addrRead, ram_data, in_data, in_valid,
      input  dataRead, readValid, BUSY, ram_addr, ram_re, in_ready
   );
endinterface

// File: rtl/subleq_read_port.sv
// SUBLEQ read-side decoder: PORT_ADDR reads come from a one-byte input buffer,
// all other addresses go to the synchronous data RAM (2-cycle latency).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | accepting RE; port reads from a full buffer complete here
// S_RAM_REQ   | ram_re/ram_addr presented, RAM captures at the next edge
// S_RAM_CAP   | ram_data valid, captured into dataRead
// S_PORT_WAIT | port read with empty buffer, waiting for an input handshake
module subleq_read_port #(
   parameter logic [7:0] PORT_ADDR = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   subleq_read_port_if.slave bus
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_RAM_REQ   = 2'd1;
   localparam logic [1:0] S_RAM_CAP   = 2'd2;
   localparam logic [1:0] S_PORT_WAIT = 2'd3;

   logic [1:0] r_state;
   logic [7:0] r_data_read;
   logic       r_read_valid;
   logic [7:0] r_ram_addr;
   logic       r_ram_re;
   logic [7:0] r_buf;
   logic       r_buf_full;
   logic       r_in_ready;

   logic       w_hs;
   logic       w_port_hit;
   logic       w_rd_req;
   logic       w_buf_pop;
   logic       w_fwd;
   logic       w_buf_push;
   logic       w_buf_full_nxt;

   assign w_hs       = bus.in_valid & r_in_ready;
   assign w_port_hit = (bus.addrRead == PORT_ADDR);
   assign w_rd_req   = (r_state == S_IDLE) & bus.RE;
   assign w_buf_pop  = w_rd_req & w_port_hit & r_buf_full;
   assign w_fwd      = (r_state == S_PORT_WAIT) & w_hs;
   assign w_buf_push = w_hs & ~w_fwd;

   // Pop and push never coincide: a full buffer holds in_ready low.
   always_comb begin
      w_buf_full_nxt = r_buf_full;
      if (w_buf_pop)
         w_buf_full_nxt = 1'b0;
      else if (w_buf_push)
         w_buf_full_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf      <= 8'h00;
         r_buf_full <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         if (w_buf_push)
            r_buf <= bus.in_data;
         r_buf_full <= w_buf_full_nxt;
         r_in_ready <= ~w_buf_full_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_data_read  <= 8'h00;
         r_read_valid <= 1'b0;
         r_ram_addr   <= 8'h00;
         r_ram_re     <= 1'b0;
      end else begin
         r_read_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.RE) begin
                  if (!w_port_hit) begin
                     r_ram_addr <= bus.addrRead;
                     r_ram_re   <= 1'b1;
                     r_state    <= S_RAM_REQ;
                  end else if (r_buf_full) begin
                     r_data_read  <= r_buf;
                     r_read_valid <= 1'b1;
                  end else begin
                     r_state <= S_PORT_WAIT;
                  end
               end
            end
            S_RAM_REQ: begin
               r_ram_re <= 1'b0;
               r_state  <= S_RAM_CAP;
            end
            S_RAM_CAP: begin
               r_data_read  <= bus.ram_data;
               r_read_valid <= 1'b1;
               r_state      <= S_IDLE;
            end
            S_PORT_WAIT: begin
               if (w_hs) begin
                  r_data_read  <= bus.in_data;
                  r_read_valid <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.dataRead  = r_data_read;
   assign bus.readValid = r_read_valid;
   assign bus.BUSY      = (r_state != S_IDLE);
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_re    = r_ram_re;
   assign bus.in_ready  = r_in_ready;

endmodule

// File: tb/tb_subleq_read_port.sv
// Bench for subleq_read_port: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_subleq_read_port;

   logic clk = 1'b0;
   logic rst;

   subleq_read_port_if u_if ();

   subleq_read_port #(.PORT_ADDR(8'h00)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
      end
   endtask

   // Synchronous RAM environment: contents are addr ^ 8'h39 (so 8'h05 -> 8'h3C).
   logic [7:0] mem [256];
   logic [7:0] ram_q = 8'h00;
   always @(posedge clk) if (u_if.ram_re) ram_q <= mem[u_if.ram_addr];
   assign u_if.ram_data = ram_q;

   // Reference model: tracks outstanding read by remaining latency, plus buffer contents.
   int         m_ram_left   = 0;
   logic [7:0] m_ram_addr   = 8'h00;
   bit         m_port_wait  = 0;
   bit         m_buf_full   = 0;
   logic [7:0] m_buf        = 8'h00;
   logic [7:0] exp_data     = 8'h00;
   logic       exp_valid    = 1'b0;
   logic       exp_busy     = 1'b0;
   logic [7:0] exp_ram_addr = 8'h00;
   logic       exp_ram_re   = 1'b0;
   logic       exp_in_ready = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ram_left = 0; m_port_wait = 0; m_buf_full = 0;
         exp_data = 8'h00; exp_valid = 1'b0; exp_busy = 1'b0;
         exp_ram_addr = 8'h00; exp_ram_re = 1'b0; exp_in_ready = 1'b0;
      end else begin
         bit busy_before, hs, forwarded;
         busy_before = (m_ram_left != 0) || m_port_wait;
         hs          = u_if.in_valid && exp_in_ready;
         forwarded   = 0;
         exp_valid   = 1'b0;
         exp_ram_re  = 1'b0;
         if (m_ram_left == 1) begin
            exp_data = mem[m_ram_addr]; exp_valid = 1'b1; m_ram_left = 0;
         end else if (m_ram_left == 2) begin
            m_ram_left = 1;
         end else if (m_port_wait && hs) begin
            exp_data = u_if.in_data; exp_valid = 1'b1; m_port_wait = 0; forwarded = 1;
         end
         if (!busy_before && u_if.RE) begin
            if (u_if.addrRead != 8'h00) begin
               m_ram_left = 2; m_ram_addr = u_if.addrRead;
               exp_ram_re = 1'b1; exp_ram_addr = u_if.addrRead;
            end else if (m_buf_full) begin
               exp_data = m_buf; exp_valid = 1'b1; m_buf_full = 0;
            end else begin
               m_port_wait = 1;
            end
         end
         if (hs && !forwarded) begin
            m_buf = u_if.in_data; m_buf_full = 1;
         end
         exp_in_ready = !m_buf_full;
         exp_busy     = (m_ram_left != 0) || m_port_wait;
      end
   end

   always @(negedge clk) begin
      check("dataRead",  u_if.dataRead,          exp_data);
      check("readValid", {7'd0, u_if.readValid}, {7'd0, exp_valid});
      check("BUSY",      {7'd0, u_if.BUSY},      {7'd0, exp_busy});
      check("ram_re",    {7'd0, u_if.ram_re},    {7'd0, exp_ram_re});
      check("ram_addr",  u_if.ram_addr,          exp_ram_addr);
      check("in_ready",  {7'd0, u_if.in_ready},  {7'd0, exp_in_ready});
   end

   int pulses;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h39;
      rst = 1'b1;
      u_if.RE = 1'b0; u_if.addrRead = 8'h00; u_if.in_data = 8'h00; u_if.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("in_ready_before_first_edge", {7'd0, u_if.in_ready}, 8'h00);
      @(negedge clk);
      check("in_ready_after_release", {7'd0, u_if.in_ready}, 8'h01);

      // Buffer a byte, then reset mid-cycle: outputs clear at once, byte discarded.
      u_if.in_valid = 1'b1; u_if.in_data = 8'h99;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      check("in_ready_full", {7'd0, u_if.in_ready}, 8'h00);
      u_if.RE = 1'b1; u_if.addrRead = 8'h05;
      @(negedge clk);
      u_if.RE = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_busy",   {7'd0, u_if.BUSY},   8'h00);
      check("rst_ram_re", {7'd0, u_if.ram_re}, 8'h00);
      check("rst_addr",   u_if.ram_addr,       8'h00);
      check("rst_ready",  {7'd0, u_if.in_ready}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {7'd0, u_if.in_ready}, 8'h01);

      // RAM read at 8'h05
      u_if.RE = 1'b1; u_if.addrRead = 8'h05;
      @(negedge clk);
      u_if.RE = 1'b0;
      check("ram_re_e0",   {7'd0, u_if.ram_re}, 8'h01);
      check("ram_addr_e0", u_if.ram_addr,       8'h05);
      check("busy_e0",     {7'd0, u_if.BUSY},   8'h01);
      @(negedge clk);
      check("ram_re_e1",   {7'd0, u_if.ram_re},    8'h00);
      check("busy_e1",     {7'd0, u_if.BUSY},      8'h01);
      check("valid_e1",    {7'd0, u_if.readValid}, 8'h00);
      @(negedge clk);
      check("valid_e2",    {7'd0, u_if.readValid}, 8'h01);
      check("data_e2",     u_if.dataRead,          8'h3C);
      check("busy_e2",     {7'd0, u_if.BUSY},      8'h00);
      @(negedge clk);
      check("valid_e3",    {7'd0, u_if.readValid}, 8'h00);
      check("data_held",   u_if.dataRead,          8'h3C);

      // Preload A5, then port read from the full buffer
      u_if.in_valid = 1'b1; u_if.in_data = 8'hA5;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      check("preload_ready", {7'd0, u_if.in_ready}, 8'h00);
      u_if.RE = 1'b1; u_if.addrRead = 8'h00;
      @(negedge clk);
      u_if.RE = 1'b0;
      check("buf_valid", {7'd0, u_if.readValid}, 8'h01);
      check("buf_data",  u_if.dataRead,          8'hA5);
      check("buf_ready", {7'd0, u_if.in_ready},  8'h01);
      check("buf_busy",  {7'd0, u_if.BUSY},      8'h00);
      @(negedge clk);

      // Port read with empty buffer: wait 5 cycles, then forward 8'h17
      u_if.RE = 1'b1; u_if.addrRead = 8'h00;
      @(negedge clk);
      u_if.RE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("wait_busy", {7'd0, u_if.BUSY}, 8'h01);
         if (i < 4) @(negedge clk);
      end
      u_if.in_valid = 1'b1; u_if.in_data = 8'h17;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      check("fwd_valid", {7'd0, u_if.readValid}, 8'h01);
      check("fwd_data",  u_if.dataRead,          8'h17);
      check("fwd_ready", {7'd0, u_if.in_ready},  8'h01);
      @(negedge clk);
      check("fwd_ready_hold", {7'd0, u_if.in_ready}, 8'h01);

      // Back-to-back: RE held into RAM_REQ is ignored
      pulses = 0;
      u_if.RE = 1'b1; u_if.addrRead = 8'h20;
      @(negedge clk);
      @(negedge clk);
      u_if.RE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (u_if.readValid) pulses++;
         @(negedge clk);
      end
      check("b2b_pulses", 8'(pulses), 8'h01);
      check("b2b_data",   u_if.dataRead, 8'h19);
      u_if.RE = 1'b1; u_if.addrRead = 8'h07;
      @(negedge clk);
      u_if.RE = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("fresh_valid", {7'd0, u_if.readValid}, 8'h01);
      check("fresh_data",  u_if.dataRead,          8'h3E);
      @(negedge clk);

      // Reset during PORT_WAIT, then a later byte is buffered, not forwarded
      u_if.RE = 1'b1; u_if.addrRead = 8'h00;
      @(negedge clk);
      u_if.RE = 1'b0;
      check("pw_busy", {7'd0, u_if.BUSY}, 8'h01);
      #2 rst = 1'b1;
      #1;
      check("pw_rst_busy", {7'd0, u_if.BUSY}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      u_if.in_valid = 1'b1; u_if.in_data = 8'h4E;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      check("pw_no_valid", {7'd0, u_if.readValid}, 8'h00);
      check("pw_buffered", {7'd0, u_if.in_ready},  8'h00);
      u_if.RE = 1'b1; u_if.addrRead = 8'h00;
      @(negedge clk);
      u_if.RE = 1'b0;
      check("pw_read_valid", {7'd0, u_if.readValid}, 8'h01);
      check("pw_read_data",  u_if.dataRead,          8'h4E);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/subleq_read_port.md
# subleq_read_port

Read-side address decoder and input port for the SUBLEQ datapath; the counterpart of the write-side port decoder. The CPU issues 8-bit reads; address `PORT_ADDR` returns a byte from an external input device through a one-entry buffer with a valid/ready handshake, and every other address is forwarded to the synchronous data RAM. The CPU stalls on `BUSY` until `readValid` pulses.

## Interface
- `PORT_ADDR`, default 8'h00, read address mapped to the input port.
- `CLK` input 1: system clock, all state updates on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `RE` input 1: read request from the CPU, sampled only in IDLE.
- `addrRead` input 8: read address, sampled with `RE`.
- `dataRead` output 8: read data (registered), valid when `readValid` = 1, held until the next read completes.
- `readValid` output 1: one-cycle pulse, read complete.
- `BUSY` output 1: high in any state other than IDLE.
- `ram_addr` output 8: registered RAM address.
- `ram_re` output 1: registered RAM read strobe.
- `ram_data` input 8: RAM read data, valid the cycle after the edge that samples `ram_re`.
- `in_data` input 8: input device byte.
- `in_valid` input 1: input device has a byte.
- `in_ready` output 1: registered; the block accepts `in_data` at any edge where `in_valid` and `in_ready` are both high.

## Operation
- State machine with four states: IDLE, RAM_REQ, RAM_CAP, PORT_WAIT.
- IDLE, `RE`=1, `addrRead`≠PORT_ADDR: latch `ram_addr`=`addrRead`, `ram_re`←1, go to RAM_REQ.
- RAM_REQ: `ram_re`←0, go to RAM_CAP.
- RAM_CAP: `dataRead`←`ram_data`, `readValid`←1, go to IDLE.
- IDLE, `RE`=1, `addrRead`=PORT_ADDR, buffer full: `dataRead`←buffer, `readValid`←1, clear the buffer, stay in IDLE.
- IDLE, `RE`=1, `addrRead`=PORT_ADDR, buffer empty: go to PORT_WAIT.
- PORT_WAIT, handshake occurs: forward `in_data` directly, with `dataRead`←`in_data` and `readValid`←1. The buffer stays empty. Go to IDLE.
- Handshake in any other situation: buffer←`in_data`, buffer becomes full.
- `in_ready` next value is the logical NOT of the next buffer-full flag. Clearing the buffer on a port read raises `in_ready` at the same edge.
- Same edge as a port read from a full buffer: `in_ready` is 0, so no capture occurs. There is no double-booking.
- `RE` is ignored while `BUSY`=1, with no queuing.
- Reset: state IDLE, buffer empty. `dataRead`=0, `readValid`=0, `ram_re`=0, `ram_addr`=0, `in_ready`=0, `BUSY`=0.
- Reset mid-operation aborts the read with no `readValid`. A buffered byte is discarded.

## Timing
- Edge E0 samples `RE`.
- RAM read:
  - `ram_re`/`ram_addr` are valid between E0 and E1.
  - The RAM captures at E1.
  - `ram_data` is valid between E1 and E2.
  - `dataRead` and `readValid` are valid after E2. Latency is 2 cycles.
  - `BUSY` is high between E0 and E2.
- Port read, buffer full: `readValid` is high after E0. Latency is 1 cycle and `BUSY` never rises.
- Port read, buffer empty: `BUSY` is high from E0 until the handshake edge. `readValid` is high after the handshake edge. The wait is unbounded.
- `in_ready` rises at the first edge after `RST` deasserts.
- `readValid` is never high for two consecutive cycles.

## Test plan
- Reset: assert `RST` mid-cycle. All outputs go to 0 immediately, and `in_ready`=1 one edge after release.
- RAM read at 8'h05, with the RAM model returning 8'h3C:
  - `ram_re`=1 and `ram_addr`=8'h05 for exactly one cycle.
  - `readValid` pulses 2 cycles after `RE` with `dataRead`=8'h3C.
  - `BUSY` is high for 2 cycles.
- Preload: handshake 8'hA5, after which `in_ready`=0. A port read then gives `readValid` one cycle later with `dataRead`=8'hA5, `in_ready`=1 again, and `BUSY` staying 0.
- Port read with the buffer empty: `BUSY` holds high for 5 cycles. `in_valid` with 8'h17 then gives `readValid` at that edge with `dataRead`=8'h17, the buffer stays empty, and `in_ready` stays 1.
- Back-to-back: `RE` to 8'h20 is pulsed again during RAM_REQ and is ignored, with one `readValid` only. A fresh `RE` in IDLE is then serviced normally.
- Reset during PORT_WAIT: no `readValid`, state IDLE, and a later `in_valid` byte is buffered rather than forwarded.
